// File: rtl/game_pkg.sv
// game_pkg: encodings shared by the turn scheduler, the VGA renderer and the top level.
package game_pkg;

    localparam int MAP_W = 20;
    localparam int MAP_H = 15;

    typedef enum logic [1:0] {
        MODE_MOVE   = 2'b00,
        MODE_ATTACK = 2'b01,
        MODE_HIT    = 2'b10,
        MODE_IDLE   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ACT_KNIGHT  = 2'd0,
        ACT_WIZARD  = 2'd1,
        ACT_MONSTER = 2'd2
    } actor_t;

    typedef enum logic [1:0] {
        ST_SELECT  = 2'd0,
        ST_ANIM    = 2'd1,
        ST_NEXT    = 2'd2,
        ST_MONSTER = 2'd3
    } sched_state_t;

endpackage

// File: rtl/anim_timer.sv
// anim_timer: free-running tick prescaler plus attack-animation frame counter.
// start restarts both counters; frames advance only while run is high, and
// done flags the tick that ends the last frame.
module anim_timer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 20,
    parameter int ANIM_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    output logic       tick,
    output logic [3:0] frame,
    output logic       done
);

    logic [TICK_DIV-1:0] prescaler;
    logic                last_frame;

    assign tick       = &prescaler;
    assign last_frame = (frame == 4'(ANIM_FRAMES - 1));
    assign done       = run && tick && last_frame;

    // Prescaler runs in every state so the timeout sees ticks too; restarted per animation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prescaler <= '0;
        else if (start)
            prescaler <= '0;
        else
            prescaler <= prescaler + TICK_DIV'(1);
    end

    // Frame index steps once per tick during an animation and folds back to 0 after the last frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame <= '0;
        else if (start)
            frame <= '0;
        else if (run && tick)
            frame <= last_frame ? 4'd0 : frame + 4'd1;
    end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences knight, wizard and monster turns and times the
// attack animations. Optional player-turn timeout: TURN_SCHEDULER_TIMEOUT_EN.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 20,
    parameter int ANIM_FRAMES   = 16,
    parameter int TIMEOUT_TICKS = 64,
    parameter int KNIGHT_POS    = 125,
    parameter int WIZARD_POS    = 167,
    parameter int MONSTER_POS   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       confirm_pulse,
    input  logic       end_pulse,
    output logic [1:0] actor,
    output logic [8:0] action_pos,
    output logic [1:0] player_mode,
    output logic       anim_active,
    output logic [3:0] anim_count,
    output logic [7:0] round_cnt,
    output logic       turn_done
);

    sched_state_t state_q, state_d;
    actor_t       actor_q, actor_d;
    mode_t        mode_q, mode_d;
    logic         active_d;
    logic [7:0]   round_d;
    logic         done_d;
    logic         start;
    logic         anim_run;
    logic         tick;
    logic         anim_done;
    logic         end_eff;

    function automatic logic [8:0] pos_of(input actor_t a);
        case (a)
            ACT_WIZARD:  pos_of = 9'(WIZARD_POS);
            ACT_MONSTER: pos_of = 9'(MONSTER_POS);
            default:     pos_of = 9'(KNIGHT_POS);
        endcase
    endfunction

    assign anim_run    = (state_q == ST_ANIM) || (state_q == ST_MONSTER);
    assign actor       = actor_q;
    assign player_mode = mode_q;

    anim_timer #(
        .TICK_DIV    (TICK_DIV),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim_timer (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .run   (anim_run),
        .tick  (tick),
        .frame (anim_count),
        .done  (anim_done)
    );

`ifdef TURN_SCHEDULER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_fire;

    // Timeout expires on the tick that would bring the count to TIMEOUT_TICKS
    assign timeout_fire = (state_q == ST_SELECT) && tick && !confirm_pulse &&
                          (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
    assign end_eff      = end_pulse || timeout_fire;

    // Timeout counter: zero outside SELECT (so zero on entry), restarted by each confirm
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if ((state_q != ST_SELECT) || confirm_pulse)
            to_cnt <= '0;
        else if (tick)
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    logic unused_timeout;

    assign end_eff        = end_pulse;
    assign unused_timeout = (TIMEOUT_TICKS != 0) ^ tick;
`endif

    // Next-state and next-output decode; end beats confirm when both arrive together
    always_comb begin
        state_d  = state_q;
        actor_d  = actor_q;
        mode_d   = mode_q;
        active_d = anim_active;
        round_d  = round_cnt;
        done_d   = 1'b0;
        start    = 1'b0;
        case (state_q)
            ST_SELECT: begin
                if (end_eff) begin
                    if (mode_q == MODE_ATTACK) begin
                        state_d  = ST_ANIM;
                        mode_d   = MODE_ATTACK;
                        active_d = 1'b1;
                        start    = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (confirm_pulse) begin
                    mode_d = (mode_q == MODE_ATTACK) ? MODE_MOVE : MODE_ATTACK;
                end
            end
            ST_ANIM: begin
                if (anim_done) begin
                    state_d  = ST_NEXT;
                    active_d = 1'b0;
                end
            end
            ST_NEXT: begin
                done_d   = 1'b1;
                active_d = 1'b0;
                if (actor_q == ACT_KNIGHT) begin
                    actor_d = ACT_WIZARD;
                    mode_d  = MODE_MOVE;
                    state_d = ST_SELECT;
                end else begin
                    actor_d  = ACT_MONSTER;
                    mode_d   = MODE_HIT;
                    state_d  = ST_MONSTER;
                    active_d = 1'b1;
                    start    = 1'b1;
                end
            end
            default: begin
                if (anim_done) begin
                    actor_d  = ACT_KNIGHT;
                    round_d  = round_cnt + 8'd1;
                    done_d   = 1'b1;
                    mode_d   = MODE_MOVE;
                    state_d  = ST_SELECT;
                    active_d = 1'b0;
                end
            end
        endcase
    end

    // State and every output are registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SELECT;
            actor_q     <= ACT_KNIGHT;
            mode_q      <= MODE_MOVE;
            anim_active <= 1'b0;
            round_cnt   <= 8'd0;
            turn_done   <= 1'b0;
            action_pos  <= 9'(KNIGHT_POS);
        end else begin
            state_q     <= state_d;
            actor_q     <= actor_d;
            mode_q      <= mode_d;
            anim_active <= active_d;
            round_cnt   <= round_d;
            turn_done   <= done_d;
            action_pos  <= pos_of(actor_d);
        end
    end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Round/turn controller for the tactics game: sequences the knight, wizard and monster turns and times each attack animation. It replaces the scattered player/actor FSMs in the top level with one registered scheduler. Its outputs feed the VGA renderer (active position, mode, frame index) and the seven-segment/LED debug outputs (round count).

## Interface
Parameters:
- TICK_DIV, 20: prescaler width; one animation tick every 2^TICK_DIV clocks.
- ANIM_FRAMES, 16: frames per attack animation (2..16).
- TIMEOUT_TICKS, 64: player-turn timeout in ticks (used only with the timeout feature).
- KNIGHT_POS, 125: map cell index of the knight (0..299).
- WIZARD_POS, 167: map cell index of the wizard.
- MONSTER_POS, 0: map cell index of the monster.

Ports:
- clk, in, 1: system clock. Reset is asynchronous and active-low.
- rst, in, 1: asynchronous reset, active-low.
- confirm_pulse, in, 1: one-cycle pulse (centre click); toggles move/attack.
- end_pulse, in, 1: one-cycle pulse (down click); commits the turn.
- actor, out, 2: 0 = knight, 1 = wizard, 2 = monster.
- action_pos, out, 9: map cell of the active actor.
- player_mode, out, 2: 00 move, 01 attack, 10 hit, 11 idle.
- anim_active, out, 1: high while an animation plays.
- anim_count, out, 4: current frame index.
- round_cnt, out, 8: number of completed rounds; wraps at 255 → 0.
- turn_done, out, 1: one-cycle pulse when the active actor advances.

## Operation
- Reset values:
  - FSM = SELECT, actor = 0, action_pos = KNIGHT_POS.
  - player_mode = move, anim_active = 0, anim_count = 0, round_cnt = 0, turn_done = 0.
  - Prescaler and timeout counter = 0.
- SELECT (actor 0 or 1):
  - confirm_pulse toggles player_mode between move and attack.
  - end_pulse with mode attack → ANIM.
  - end_pulse with mode move → NEXT.
- ANIM:
  - On entry: anim_active = 1, anim_count = 0, prescaler = 0, player_mode = attack.
  - Each tick increments anim_count.
  - A tick while anim_count == ANIM_FRAMES-1 → NEXT.
- NEXT (one cycle):
  - turn_done = 1, anim_active = 0.
  - Actor 0 → actor 1, SELECT, mode = move.
  - Actor 1 → actor 2, MONSTER.
- MONSTER:
  - On entry: anim_active = 1, anim_count = 0, prescaler = 0, player_mode = hit.
  - Final tick as in ANIM, then: actor = 0, round_cnt += 1, turn_done = 1, SELECT, mode = move.
- action_pos is always the POS parameter of the current actor.
- confirm_pulse and end_pulse are ignored outside SELECT.
- confirm_pulse and end_pulse in the same cycle: end wins, the mode before the toggle is used, and no toggle occurs.
- Tick: the prescaler is free-running in all states and is cleared on ANIM/MONSTER entry; tick asserts when it equals all-ones.
- Reset asserted mid-animation returns all outputs to reset values immediately, without waiting for a clock.

## Timing
- All outputs are registered. State and outputs change on the clock edge after the sampled pulse; there is no combinational path from input to output.
- First animation tick occurs exactly 2^TICK_DIV clocks after ANIM/MONSTER entry.
- ANIM duration: ANIM_FRAMES·2^TICK_DIV clocks, plus 1 clock for NEXT.
- From end_pulse (mode move) to the next actor being visible: 2 clocks (SELECT→NEXT→SELECT).
- turn_done is exactly 1 clock wide.
- Monster completion: the same edge updates round_cnt, actor and turn_done.

## Configuration
- TURN_SCHEDULER_TIMEOUT_EN:
  - Defined: a timeout counter clears on SELECT entry and on every confirm_pulse, and counts ticks in SELECT. On reaching TIMEOUT_TICKS, the block acts as if end_pulse had arrived with the current mode. If a real end_pulse arrives on the same cycle, it is processed once, not twice.
  - Undefined: there is no counter and SELECT waits indefinitely.

## Structure
- Shared package game_pkg holds:
  - mode encodings MODE_MOVE/ATTACK/HIT/IDLE;
  - actor encodings ACT_KNIGHT/WIZARD/MONSTER;
  - MAP_W = 20, MAP_H = 15.
  The VGA block and the top level import the same package.
- One sub-module, anim_timer: prescaler, tick generation, frame counter and done flag, with a start input (clears counters) and ANIM_FRAMES/TICK_DIV parameters.
- FSM, actor/round registers and the timeout counter stay in turn_scheduler.

## Test plan
All scenarios use TICK_DIV = 2, ANIM_FRAMES = 4, TIMEOUT_TICKS = 3.
- Reset: hold rst = 0, then release → actor = 0, action_pos = 125, mode = 00, round_cnt = 0, turn_done = 0.
- Skip turn: end_pulse in move mode → turn_done high for 1 clock two cycles later, actor = 1, action_pos = 167. A second end_pulse → MONSTER, mode = 10; after 16 clocks plus 1 → actor = 0, round_cnt = 1.
- Attack: confirm_pulse then end_pulse → mode = 01, anim_active = 1, anim_count steps 0, 1, 2, 3 every 4 clocks, then NEXT, actor = 1, mode = 00.
- Simultaneous pulses: confirm_pulse and end_pulse in the same cycle in move mode → NEXT (no attack); both pulses during ANIM → ignored.
- Reset mid-animation: assert rst at anim_count = 2 → all outputs return to reset values asynchronously, before the next edge.
- With TURN_SCHEDULER_TIMEOUT_EN defined and no input → actor advances after 3 ticks (12 clocks) in SELECT. A confirm_pulse at tick 2 restarts the count.
